// File: rtl/bp_be_fe_cmd_gen.sv
// bp_be_fe_cmd_gen: classifies resolved branches, issues one-cycle FE redirects and
// buffers attaboy training updates behind a valid/yumi handshake with ageing and drop counting.
module bp_be_fe_cmd_gen #(
    parameter int vaddr_width_p               = 39,
    parameter int branch_metadata_fwd_width_p = 64,
    parameter int attaboy_els_p               = 4,
    parameter int force_age_p                 = 8,
    parameter int drop_ctr_width_p            = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   br_v_i,
    input  logic                                   br_epoch_i,
    input  logic                                   br_is_branch_i,
    input  logic                                   br_taken_i,
    input  logic [vaddr_width_p-1:0]               br_tgt_i,
    input  logic [vaddr_width_p-1:0]               br_npc_i,
    input  logic [vaddr_width_p-1:0]               br_pred_npc_i,
    input  logic [branch_metadata_fwd_width_p-1:0] br_metadata_fwd_i,
    input  logic                                   exc_redirect_v_i,
    input  logic [vaddr_width_p-1:0]               exc_redirect_npc_i,
    output logic                                   epoch_o,
    output logic                                   redirect_v_o,
    output logic [vaddr_width_p-1:0]               redirect_pc_o,
    output logic [vaddr_width_p-1:0]               redirect_npc_o,
    output logic                                   redirect_br_v_o,
    output logic                                   redirect_br_taken_o,
    output logic                                   redirect_br_ntaken_o,
    output logic                                   redirect_br_nonbr_o,
    output logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o,
    output logic                                   attaboy_v_o,
    output logic                                   attaboy_force_o,
    output logic [vaddr_width_p-1:0]               attaboy_pc_o,
    output logic                                   attaboy_taken_o,
    output logic                                   attaboy_ntaken_o,
    output logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o,
    input  logic                                   attaboy_yumi_i,
    output logic [drop_ctr_width_p-1:0]            attaboy_drop_cnt_o
);
    localparam int ptr_w = $clog2(attaboy_els_p);
    localparam int age_w = $clog2(force_age_p + 1);
    localparam logic [0:0] e_run      = 1'b0;
    localparam logic [0:0] e_redirect = 1'b1;

    logic [0:0]                             state_q, state_d;
    logic                                   epoch_q, epoch_d;
    logic [vaddr_width_p-1:0]               rd_pc_q, rd_npc_q;
    logic                                   rd_br_v_q, rd_taken_q, rd_ntaken_q, rd_nonbr_q;
    logic [branch_metadata_fwd_width_p-1:0] rd_meta_q;
    logic [ptr_w:0]                         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [age_w-1:0]                       age_q, age_d;
    logic [drop_ctr_width_p-1:0]            drop_q, drop_d;

    logic [vaddr_width_p-1:0]               mem_pc    [attaboy_els_p];
    logic                                   mem_taken [attaboy_els_p];
    logic [branch_metadata_fwd_width_p-1:0] mem_meta  [attaboy_els_p];

    logic acc, mis, redir, push_req, push, pop, empty, full, aged;

    always_comb begin
        acc      = br_v_i & (br_epoch_i == epoch_q);
        mis      = acc & (br_npc_i != br_pred_npc_i);
        redir    = exc_redirect_v_i | mis;
        state_d  = redir ? e_redirect : e_run;
        epoch_d  = epoch_q ^ redir;
        empty    = wptr_q == rptr_q;
        full     = wptr_q == {~rptr_q[ptr_w], rptr_q[ptr_w-1:0]};
        pop      = attaboy_yumi_i & ~empty;
        push_req = acc & ~mis & br_is_branch_i & ~exc_redirect_v_i;
        // A full FIFO still accepts the push when the head leaves on the same edge.
        push     = push_req & (~full | pop);
        wptr_d   = wptr_q + (ptr_w+1)'(push);
        rptr_d   = rptr_q + (ptr_w+1)'(pop);
        drop_d   = (push_req & full & ~pop & ~&drop_q) ? drop_q + 1'b1 : drop_q;
        aged     = age_q == age_w'(force_age_p);
        age_d    = (empty | pop) ? '0 : (aged ? age_q : age_q + 1'b1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_run;
            epoch_q     <= 1'b0;
            rd_pc_q     <= '0;
            rd_npc_q    <= '0;
            rd_br_v_q   <= 1'b0;
            rd_taken_q  <= 1'b0;
            rd_ntaken_q <= 1'b0;
            rd_nonbr_q  <= 1'b0;
            rd_meta_q   <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            age_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q <= state_d;
            epoch_q <= epoch_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            age_q   <= age_d;
            drop_q  <= drop_d;
            if (redir) begin
                rd_pc_q     <= exc_redirect_v_i ? '0 : br_tgt_i;
                rd_npc_q    <= exc_redirect_v_i ? exc_redirect_npc_i : br_npc_i;
                rd_br_v_q   <= ~exc_redirect_v_i;
                rd_taken_q  <= ~exc_redirect_v_i & br_is_branch_i & br_taken_i;
                rd_ntaken_q <= ~exc_redirect_v_i & br_is_branch_i & ~br_taken_i;
                rd_nonbr_q  <= ~exc_redirect_v_i & ~br_is_branch_i;
                rd_meta_q   <= exc_redirect_v_i ? '0 : br_metadata_fwd_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[wptr_q[ptr_w-1:0]]    <= br_tgt_i;
            mem_taken[wptr_q[ptr_w-1:0]] <= br_taken_i;
            mem_meta[wptr_q[ptr_w-1:0]]  <= br_metadata_fwd_i;
        end
    end

    assign epoch_o                    = epoch_q;
    assign redirect_v_o               = state_q == e_redirect;
    assign redirect_pc_o              = redirect_v_o ? rd_pc_q : '0;
    assign redirect_npc_o             = redirect_v_o ? rd_npc_q : '0;
    assign redirect_br_v_o            = redirect_v_o & rd_br_v_q;
    assign redirect_br_taken_o        = redirect_v_o & rd_taken_q;
    assign redirect_br_ntaken_o       = redirect_v_o & rd_ntaken_q;
    assign redirect_br_nonbr_o        = redirect_v_o & rd_nonbr_q;
    assign redirect_br_metadata_fwd_o = redirect_v_o ? rd_meta_q : '0;
    // The FE predictor write port is shared, so a redirect hides the attaboy head.
    assign attaboy_v_o                = ~empty & ~redirect_v_o;
    assign attaboy_force_o            = attaboy_v_o & aged;
    assign attaboy_pc_o               = attaboy_v_o ? mem_pc[rptr_q[ptr_w-1:0]] : '0;
    assign attaboy_taken_o            = attaboy_v_o & mem_taken[rptr_q[ptr_w-1:0]];
    assign attaboy_ntaken_o           = attaboy_v_o & ~mem_taken[rptr_q[ptr_w-1:0]];
    assign attaboy_br_metadata_fwd_o  = attaboy_v_o ? mem_meta[rptr_q[ptr_w-1:0]] : '0;
    assign attaboy_drop_cnt_o         = drop_q;

    yumi_protocol: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(attaboy_yumi_i && !attaboy_v_o));
endmodule

// File: tb/tb_bp_be_fe_cmd_gen.sv
// tb_bp_be_fe_cmd_gen: directed self-checking bench for bp_be_fe_cmd_gen.
module tb_bp_be_fe_cmd_gen;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        br_v, br_epoch, br_is_branch, br_taken;
    logic [38:0] br_tgt, br_npc, br_pred_npc;
    logic [63:0] br_meta;
    logic        exc_v;
    logic [38:0] exc_npc;
    logic        epoch, rd_v, rd_br_v, rd_taken, rd_ntaken, rd_nonbr;
    logic [38:0] rd_pc, rd_npc;
    logic [63:0] rd_meta;
    logic        ab_v, ab_force, ab_taken, ab_ntaken, yumi;
    logic [38:0] ab_pc;
    logic [63:0] ab_meta;
    logic [15:0] drop_cnt;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    bp_be_fe_cmd_gen dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .br_v_i(br_v), .br_epoch_i(br_epoch), .br_is_branch_i(br_is_branch),
        .br_taken_i(br_taken), .br_tgt_i(br_tgt), .br_npc_i(br_npc),
        .br_pred_npc_i(br_pred_npc), .br_metadata_fwd_i(br_meta),
        .exc_redirect_v_i(exc_v), .exc_redirect_npc_i(exc_npc),
        .epoch_o(epoch), .redirect_v_o(rd_v), .redirect_pc_o(rd_pc),
        .redirect_npc_o(rd_npc), .redirect_br_v_o(rd_br_v),
        .redirect_br_taken_o(rd_taken), .redirect_br_ntaken_o(rd_ntaken),
        .redirect_br_nonbr_o(rd_nonbr), .redirect_br_metadata_fwd_o(rd_meta),
        .attaboy_v_o(ab_v), .attaboy_force_o(ab_force), .attaboy_pc_o(ab_pc),
        .attaboy_taken_o(ab_taken), .attaboy_ntaken_o(ab_ntaken),
        .attaboy_br_metadata_fwd_o(ab_meta), .attaboy_yumi_i(yumi),
        .attaboy_drop_cnt_o(drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic idle();
        br_v = 0; br_epoch = 0; br_is_branch = 0; br_taken = 0;
        br_tgt = '0; br_npc = '0; br_pred_npc = '0; br_meta = '0;
        exc_v = 0; exc_npc = '0; yumi = 0;
    endtask

    task automatic drive_br(input logic ep, input logic isb, input logic tk,
                            input logic [38:0] tgt, input logic [38:0] npc,
                            input logic [38:0] pred, input logic [63:0] meta);
        br_v = 1; br_epoch = ep; br_is_branch = isb; br_taken = tk;
        br_tgt = tgt; br_npc = npc; br_pred_npc = pred; br_meta = meta;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        drive_br(0, 1, 1, 39'h1000, 39'h1000, 39'h0ffc, 64'h1);
        exc_v = 1; exc_npc = 39'h77;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_redirect_v", 64'(rd_v), 64'd0);
        chk("reset_redirect_npc", 64'(rd_npc), 64'd0);
        chk("reset_epoch", 64'(epoch), 64'd0);
        chk("reset_attaboy_v", 64'(ab_v), 64'd0);
        chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
        idle();
        #2 reset_n = 1;
        step();
        chk("post_reset_epoch", 64'(epoch), 64'd0);
        chk("post_reset_attaboy_v", 64'(ab_v), 64'd0);
        chk("post_reset_redirect_v", 64'(rd_v), 64'd0);
    endtask

    task automatic test_mispredict();
        drive_br(0, 1, 1, 39'h1000, 39'h1000, 39'h0ffc, 64'ha5a5);
        step();
        chk("mis_redirect_v", 64'(rd_v), 64'd1);
        chk("mis_npc", 64'(rd_npc), 64'h1000);
        chk("mis_pc", 64'(rd_pc), 64'h1000);
        chk("mis_br_v", 64'(rd_br_v), 64'd1);
        chk("mis_taken", 64'(rd_taken), 64'd1);
        chk("mis_ntaken", 64'(rd_ntaken), 64'd0);
        chk("mis_nonbr", 64'(rd_nonbr), 64'd0);
        chk("mis_meta", rd_meta, 64'ha5a5);
        chk("mis_epoch", 64'(epoch), 64'd1);
        step();
        chk("mis_one_cycle", 64'(rd_v), 64'd0);
        chk("mis_payload_zero", 64'(rd_npc), 64'd0);
    endtask

    task automatic test_wrong_path();
        drive_br(0, 1, 0, 39'h2000, 39'h2000, 39'h3000, 64'h5);
        step();
        chk("wp_no_redirect", 64'(rd_v), 64'd0);
        chk("wp_epoch", 64'(epoch), 64'd1);
        drive_br(0, 1, 1, 39'h2100, 39'h2100, 39'h2100, 64'h6);
        step();
        step();
        chk("wp_no_push", 64'(ab_v), 64'd0);
    endtask

    task automatic test_nonbranch();
        drive_br(1, 0, 1, 39'h40, 39'h44, 39'h80, 64'h9);
        step();
        chk("nonbr_redirect_v", 64'(rd_v), 64'd1);
        chk("nonbr_flag", 64'(rd_nonbr), 64'd1);
        chk("nonbr_taken", 64'(rd_taken), 64'd0);
        chk("nonbr_ntaken", 64'(rd_ntaken), 64'd0);
        chk("nonbr_epoch", 64'(epoch), 64'd0);
        step();
        drive_br(0, 0, 1, 39'h50, 39'h54, 39'h54, 64'h0);
        step();
        step();
        chk("nonbr_correct_no_push", 64'(ab_v), 64'd0);
    endtask

    task automatic test_fifo_full();
        logic [38:0] exp_pc [4];
        exp_pc[0] = 39'h104; exp_pc[1] = 39'h108; exp_pc[2] = 39'h10c; exp_pc[3] = 39'h200;
        for (int i = 0; i < 5; i++) begin
            drive_br(0, 1, i[0], 39'h100 + 39'(i * 4), 39'h900, 39'h900, 64'(i + 16));
            step();
            if (i == 0) begin
                chk("fifo_first_v", 64'(ab_v), 64'd1);
                chk("fifo_first_pc", 64'(ab_pc), 64'h100);
                chk("fifo_first_ntaken", 64'(ab_ntaken), 64'd1);
                chk("fifo_first_meta", ab_meta, 64'd16);
            end
        end
        chk("fifo_drop_one", 64'(drop_cnt), 64'd1);
        drive_br(0, 1, 1, 39'h200, 39'h900, 39'h900, 64'h20);
        yumi = 1;
        step();
        chk("fifo_pop_push_no_drop", 64'(drop_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("fifo_drain_pc", 64'(ab_pc), 64'(exp_pc[i]));
            yumi = 1;
            step();
        end
        chk("fifo_empty", 64'(ab_v), 64'd0);
    endtask

    task automatic test_force();
        drive_br(0, 1, 1, 39'h300, 39'h900, 39'h900, 64'h0);
        step();
        drive_br(0, 1, 0, 39'h304, 39'h900, 39'h900, 64'h0);
        step();
        repeat (6) step();
        chk("force_age7", 64'(ab_force), 64'd0);
        step();
        chk("force_age8", 64'(ab_force), 64'd1);
        step();
        chk("force_saturate", 64'(ab_force), 64'd1);
        yumi = 1;
        step();
        chk("force_cleared", 64'(ab_force), 64'd0);
        chk("force_next_head", 64'(ab_pc), 64'h304);
        repeat (7) step();
        chk("force_next_age7", 64'(ab_force), 64'd0);
        step();
        chk("force_next_age8", 64'(ab_force), 64'd1);
        yumi = 1;
        step();
        chk("force_drained", 64'(ab_v), 64'd0);
    endtask

    task automatic test_collision();
        drive_br(0, 1, 1, 39'h400, 39'h900, 39'h900, 64'h0);
        step();
        chk("coll_head_v", 64'(ab_v), 64'd1);
        drive_br(0, 1, 0, 39'h500, 39'h500, 39'h504, 64'hff);
        exc_v = 1; exc_npc = 39'h8000;
        step();
        chk("coll_redirect_v", 64'(rd_v), 64'd1);
        chk("coll_npc", 64'(rd_npc), 64'h8000);
        chk("coll_br_v", 64'(rd_br_v), 64'd0);
        chk("coll_meta", rd_meta, 64'd0);
        chk("coll_attaboy_masked", 64'(ab_v), 64'd0);
        chk("coll_epoch", 64'(epoch), 64'd1);
        step();
        chk("coll_redirect_done", 64'(rd_v), 64'd0);
        chk("coll_head_back", 64'(ab_pc), 64'h400);
        exc_v = 1; exc_npc = 39'h9000;
        step();
        exc_v = 1; exc_npc = 39'h9100;
        step();
        chk("b2b_redirect_v", 64'(rd_v), 64'd1);
        chk("b2b_npc", 64'(rd_npc), 64'h9100);
        chk("b2b_epoch", 64'(epoch), 64'd1);
        step();
        chk("b2b_done", 64'(rd_v), 64'd0);
        yumi = 1;
        step();
        chk("coll_drained", 64'(ab_v), 64'd0);
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_wrong_path();
        test_nonbranch();
        test_fifo_full();
        test_force();
        test_collision();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
